// File: rtl/snoop_pkg.sv
// Shared types for the MESI snoop responder.
// Holds the MESI line-state and bus-transaction encodings, the responder
// FSM states, and helpers that derive set-index and tag widths from the
// cache geometry.
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_E = 2'd2,
    ST_M = 2'd3
  } mesi_state_t;

  typedef enum logic [1:0] {
    TX_NONE = 2'd0,
    TX_RD   = 2'd1,
    TX_RDX  = 2'd2,
    TX_UPGR = 2'd3
  } bus_tx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND,
    UPDATE,
    ACK
  } snoop_fsm_t;

  function automatic int idx_width(input int num_sets);
    return (num_sets > 1) ? $clog2(num_sets) : 1;
  endfunction

  function automatic int tag_width(input int xlen, input int num_sets, input int off_w);
    return xlen - idx_width(num_sets) - off_w;
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Snoop-bus broadcast channel as seen by one responder.
//   bus_valid/bus_src/bus_tx/bus_addr : broadcast message from the issuer
//   snoop_ack/snoop_shared            : per-responder completion + shared hint
// master = issuer side, slave = responder side.
interface snoop_responder_if #(
  parameter int NUM_CPUS = 4,
  parameter int XLEN     = 32,
  localparam int SW      = $clog2(NUM_CPUS)
);
  logic            bus_valid;
  logic [SW-1:0]   bus_src;
  logic [1:0]      bus_tx;
  logic [XLEN-1:0] bus_addr;
  logic            snoop_ack;
  logic            snoop_shared;

  modport master (
    output bus_valid, bus_src, bus_tx, bus_addr,
    input  snoop_ack, snoop_shared
  );

  modport slave (
    input  bus_valid, bus_src, bus_tx, bus_addr,
    output snoop_ack, snoop_shared
  );
endinterface

// File: rtl/snoop_decide.sv
// Pure MESI snoop transition table.
//   tx         : incoming bus transaction
//   state      : current local state (ST_I for a miss)
//   next_state : state the local line must move to
//   supply     : line must be sent cache-to-cache
//   wb         : supplied line is dirty and also goes to memory
//   err        : BUS_UPGR seen while this cache owns the line
module snoop_decide
  import snoop_pkg::*;
(
  input  bus_tx_t     tx,
  input  mesi_state_t state,
  output mesi_state_t next_state,
  output logic        supply,
  output logic        wb,
  output logic        err
);

  always_comb begin
    next_state = state;
    supply     = 1'b0;
    wb         = 1'b0;
    err        = 1'b0;
    case (tx)
      TX_RD: begin
        if (state == ST_M || state == ST_E) begin
          next_state = ST_S;
          supply     = 1'b1;
          wb         = (state == ST_M);
        end
      end
      TX_RDX: begin
        if (state != ST_I) begin
          next_state = ST_I;
          supply     = (state == ST_M || state == ST_E);
          wb         = (state == ST_M);
        end
      end
      TX_UPGR: begin
        if (state == ST_S) begin
          next_state = ST_I;
        end else if (state == ST_M || state == ST_E) begin
          err = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snoop_responder.sv
// Snoop-side responder placed beside each cache.
// Captures a broadcast bus message, reads the addressed set, supplies
// M/E data over the crossbar, downgrades/invalidates the local line and
// acknowledges with a shared indication.
//   clk, rst_n        : clock, async active-low reset
//   bus               : snoop broadcast channel (slave side)
//   lk_*              : combinational read port into the local tag/data array
//   upd_*             : one-cycle state write strobe into the local array
//   xo_*              : cache-to-cache data message towards bus_src
//   proto_err         : sticky, BUS_UPGR hit a local M/E line
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int ID       = 0,
  parameter int NUM_CPUS = 4,
  parameter int NUM_SETS = 16,
  parameter int XLEN     = 32,
  parameter int LINE_W   = 256,
  parameter int OFF_W    = 5,
  localparam int SW      = $clog2(NUM_CPUS),
  localparam int IW      = idx_width(NUM_SETS),
  localparam int TAG_W   = tag_width(XLEN, NUM_SETS, OFF_W)
)(
  input  logic              clk,
  input  logic              rst_n,
  snoop_responder_if.slave  bus,
  output logic [IW-1:0]     lk_set,
  input  logic [1:0]        lk_state,
  input  logic [TAG_W-1:0]  lk_tag,
  input  logic [LINE_W-1:0] lk_data,
  input  logic              lk_busy,
  output logic              upd_valid,
  output logic [IW-1:0]     upd_set,
  output logic [1:0]        upd_state,
  output logic              xo_valid,
  output logic [SW-1:0]     xo_dst,
  output logic              xo_wb,
  output logic [LINE_W-1:0] xo_data,
  input  logic              xo_ready,
  output logic              proto_err
);

  snoop_fsm_t        state_q, state_d;
  logic [SW-1:0]     src_q;
  bus_tx_t           tx_q;
  logic [IW-1:0]     idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              hit_q;
  logic              wb_q;
  logic              upd_q;
  logic              done_q;
  logic              err_q;
  mesi_state_t       new_q;
  logic [LINE_W-1:0] data_q;

  logic        accept;
  logic        lk_hit;
  mesi_state_t lk_cur;
  mesi_state_t dec_next;
  logic        dec_supply, dec_wb, dec_err;

  assign accept = (bus_tx_t'(bus.bus_tx) != TX_NONE) && (bus.bus_src != SW'(ID));
  assign lk_hit = (mesi_state_t'(lk_state) != ST_I) && (lk_tag == tag_q);
  assign lk_cur = lk_hit ? mesi_state_t'(lk_state) : ST_I;

  snoop_decide u_decide (
    .tx         (tx_q),
    .state      (lk_cur),
    .next_state (dec_next),
    .supply     (dec_supply),
    .wb         (dec_wb),
    .err        (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      tx_q    <= TX_NONE;
      idx_q   <= '0;
      tag_q   <= '0;
      hit_q   <= 1'b0;
      wb_q    <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      new_q   <= ST_I;
      data_q  <= '0;
    end else begin
      state_q <= state_d;

      // done is only armed if the issuer still holds the message at ack time;
      // it stays set until bus_valid drops so the same message is not re-run.
      if (state_q == ACK) begin
        done_q <= bus.bus_valid;
      end else if (!bus.bus_valid) begin
        done_q <= 1'b0;
      end

      if (state_q == IDLE && bus.bus_valid && !done_q) begin
        src_q <= bus.bus_src;
        tx_q  <= bus_tx_t'(bus.bus_tx);
        idx_q <= bus.bus_addr[OFF_W +: IW];
        tag_q <= bus.bus_addr[XLEN-1 -: TAG_W];
        hit_q <= 1'b0;
        upd_q <= 1'b0;
      end

      if (state_q == LOOKUP && !lk_busy) begin
        hit_q  <= lk_hit;
        data_q <= lk_data;
        new_q  <= dec_next;
        wb_q   <= dec_wb;
        upd_q  <= lk_hit && (dec_next != lk_cur);
        if (lk_hit && dec_err) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.snoop_ack    = 1'b0;
    bus.snoop_shared = 1'b0;
    upd_valid        = 1'b0;
    xo_valid         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.bus_valid && !done_q) begin
          state_d = accept ? LOOKUP : ACK;
        end
      end
      LOOKUP: begin
        if (!lk_busy) begin
          if (!lk_hit)         state_d = ACK;
          else if (dec_supply) state_d = SEND;
          else                 state_d = UPDATE;
        end
      end
      SEND: begin
        xo_valid = 1'b1;
        if (xo_ready) state_d = UPDATE;
      end
      UPDATE: begin
        upd_valid = upd_q;
        state_d   = ACK;
      end
      ACK: begin
        bus.snoop_ack    = 1'b1;
        bus.snoop_shared = hit_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lk_set    = idx_q;
  assign upd_set   = idx_q;
  assign upd_state = new_q;
  assign xo_dst    = src_q;
  assign xo_wb     = wb_q;
  assign xo_data   = data_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with ID=1, 4 cores, 16 sets.
// The local cache array is a small table driven combinationally from lk_set.
module tb_snoop_responder;

  logic         clk;
  logic         rst_n;
  logic [3:0]   lk_set;
  logic [1:0]   lk_state;
  logic [22:0]  lk_tag;
  logic [255:0] lk_data;
  logic         lk_busy;
  logic         upd_valid;
  logic [3:0]   upd_set;
  logic [1:0]   upd_state;
  logic         xo_valid;
  logic [1:0]   xo_dst;
  logic         xo_wb;
  logic [255:0] xo_data;
  logic         xo_ready;
  logic         proto_err;

  logic [1:0]   cst  [16];
  logic [22:0]  ctag [16];
  logic [255:0] cdat [16];

  int checks;
  int errors;

  int           ack_cyc, upd_cnt, upd_cyc, xo_cnt, xo_first, extra_acks;
  logic         shared_o, xo_stable, xo_wb_o;
  logic [3:0]   upd_set_o;
  logic [1:0]   upd_state_o, xo_dst_o;
  logic [255:0] xo_data_o;

  logic [255:0] D1;
  logic [255:0] D2;
  logic [31:0]  A3;

  snoop_responder_if #(.NUM_CPUS(4), .XLEN(32)) bus ();

  snoop_responder #(.ID(1), .NUM_CPUS(4), .NUM_SETS(16), .XLEN(32), .LINE_W(256), .OFF_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .lk_set    (lk_set),
    .lk_state  (lk_state),
    .lk_tag    (lk_tag),
    .lk_data   (lk_data),
    .lk_busy   (lk_busy),
    .upd_valid (upd_valid),
    .upd_set   (upd_set),
    .upd_state (upd_state),
    .xo_valid  (xo_valid),
    .xo_dst    (xo_dst),
    .xo_wb     (xo_wb),
    .xo_data   (xo_data),
    .xo_ready  (xo_ready),
    .proto_err (proto_err)
  );

  assign lk_state = cst[lk_set];
  assign lk_tag   = ctag[lk_set];
  assign lk_data  = cdat[lk_set];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_addr(input logic [22:0] tag, input logic [3:0] set);
    return {tag, set, 5'b0};
  endfunction

  // Drives one message (inputs change on the falling edge, the next rising
  // edge is the capture edge = cycle 0) and records what the DUT does in
  // cycles 1.. until ack. Observations are sampled on falling edges.
  task automatic run_msg(input logic [1:0] src, input logic [1:0] tx, input logic [31:0] addr,
                         input int ready_delay, input int busy_cyc, input int hold_after);
    ack_cyc = -1; shared_o = 1'b0; upd_cnt = 0; upd_cyc = -1; upd_set_o = '0; upd_state_o = '0;
    xo_cnt = 0; xo_first = -1; xo_stable = 1'b1; xo_wb_o = 1'b0; xo_dst_o = '0; xo_data_o = '0;
    extra_acks = 0;
    bus.bus_valid = 1'b1;
    bus.bus_src   = src;
    bus.bus_tx    = tx;
    bus.bus_addr  = addr;
    xo_ready = (ready_delay == 0);
    lk_busy  = (busy_cyc > 0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (xo_valid) begin
        if (xo_cnt == 0) begin
          xo_first = c; xo_dst_o = xo_dst; xo_wb_o = xo_wb; xo_data_o = xo_data;
        end else if (xo_dst !== xo_dst_o || xo_wb !== xo_wb_o || xo_data !== xo_data_o) begin
          xo_stable = 1'b0;
        end
        xo_cnt++;
        if (xo_cnt == ready_delay + 1) xo_ready = 1'b1;
      end
      if (upd_valid) begin
        upd_cnt++; upd_cyc = c; upd_set_o = upd_set; upd_state_o = upd_state;
      end
      if (c == busy_cyc + 1) lk_busy = 1'b0;
      if (bus.snoop_ack) begin
        ack_cyc = c; shared_o = bus.snoop_shared;
        break;
      end
    end
    xo_ready = 1'b0;
    lk_busy  = 1'b0;
    for (int h = 0; h < hold_after; h++) begin
      @(negedge clk);
      if (bus.snoop_ack) extra_acks++;
      if (upd_valid) upd_cnt++;
      if (xo_valid) xo_cnt++;
    end
    bus.bus_valid = 1'b0;
    @(negedge clk);
    if (bus.snoop_ack) extra_acks++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.snoop_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.snoop_ack); end
    checks++; if (bus.snoop_shared !== 1'b0) begin errors++; $display("FAIL reset_shared got %b want 0", bus.snoop_shared); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd_valid); end
    checks++; if (xo_valid !== 1'b0) begin errors++; $display("FAIL reset_xo got %b want 0", xo_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", proto_err); end
    checks++; if (lk_set !== 4'd0) begin errors++; $display("FAIL reset_lk_set got %0d want 0", lk_set); end
    checks++; if (xo_data !== 256'd0) begin errors++; $display("FAIL reset_xo_data got %h want 0", xo_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rd_m();
    cst[3] = 2'd3; ctag[3] = 23'h12; cdat[3] = D1;
    run_msg(2'd2, 2'd1, A3, 0, 0, 0);
    checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL rd_m_ack_cyc got %0d want 4", ack_cyc); end
    checks++; if (shared_o !== 1'b1) begin errors++; $display("FAIL rd_m_shared got %b want 1", shared_o); end
    checks++; if (xo_cnt !== 1) begin errors++; $display("FAIL rd_m_xo_cnt got %0d want 1", xo_cnt); end
    checks++; if (xo_first !== 2) begin errors++; $display("FAIL rd_m_xo_first got %0d want 2", xo_first); end
    checks++; if (xo_dst_o !== 2'd2) begin errors++; $display("FAIL rd_m_dst got %0d want 2", xo_dst_o); end
    checks++; if (xo_wb_o !== 1'b1) begin errors++; $display("FAIL rd_m_wb got %b want 1", xo_wb_o); end
    checks++; if (xo_data_o !== D1) begin errors++; $display("FAIL rd_m_data got %h want %h", xo_data_o, D1); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL rd_m_upd_cnt got %0d want 1", upd_cnt); end
    checks++; if (upd_cyc !== 3) begin errors++; $display("FAIL rd_m_upd_cyc got %0d want 3", upd_cyc); end
    checks++; if (upd_set_o !== 4'd3) begin errors++; $display("FAIL rd_m_upd_set got %0d want 3", upd_set_o); end
    checks++; if (upd_state_o !== 2'd1) begin errors++; $display("FAIL rd_m_upd_state got %0d want 1", upd_state_o); end
    checks++; if (extra_acks !== 0) begin errors++; $display("FAIL rd_m_ack_pulse got %0d want 0", extra_acks); end
  endtask

  task automatic test_rdx_e_stall();
    cst[3] = 2'd2; ctag[3] = 23'h12; cdat[3] = D2;
    run_msg(2'd0, 2'd2, A3, 5, 0, 0);
    checks++; if (xo_cnt !== 6) begin errors++; $display("FAIL rdx_xo_cnt got %0d want 6", xo_cnt); end
    checks++; if (xo_stable !== 1'b1) begin errors++; $display("FAIL rdx_xo_stable got %b want 1", xo_stable); end
    checks++; if (xo_dst_o !== 2'd0) begin errors++; $display("FAIL rdx_dst got %0d want 0", xo_dst_o); end
    checks++; if (xo_wb_o !== 1'b0) begin errors++; $display("FAIL rdx_wb got %b want 0", xo_wb_o); end
    checks++; if (xo_data_o !== D2) begin errors++; $display("FAIL rdx_data got %h want %h", xo_data_o, D2); end
    checks++; if (upd_cyc !== 8) begin errors++; $display("FAIL rdx_upd_cyc got %0d want 8", upd_cyc); end
    checks++; if (upd_state_o !== 2'd0) begin errors++; $display("FAIL rdx_upd_state got %0d want 0", upd_state_o); end
    checks++; if (ack_cyc !== 9) begin errors++; $display("FAIL rdx_ack_cyc got %0d want 9", ack_cyc); end
    checks++; if (shared_o !== 1'b1) begin errors++; $display("FAIL rdx_shared got %b want 1", shared_o); end
  endtask

  task automatic test_upgr();
    cst[3] = 2'd1; ctag[3] = 23'h12;
    run_msg(2'd2, 2'd3, A3, 0, 0, 0);
    checks++; if (xo_cnt !== 0) begin errors++; $display("FAIL upgr_s_xo got %0d want 0", xo_cnt); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL upgr_s_upd_cnt got %0d want 1", upd_cnt); end
    checks++; if (upd_cyc !== 2) begin errors++; $display("FAIL upgr_s_upd_cyc got %0d want 2", upd_cyc); end
    checks++; if (upd_state_o !== 2'd0) begin errors++; $display("FAIL upgr_s_upd_state got %0d want 0", upd_state_o); end
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL upgr_s_ack_cyc got %0d want 3", ack_cyc); end
    checks++; if (shared_o !== 1'b1) begin errors++; $display("FAIL upgr_s_shared got %b want 1", shared_o); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL upgr_s_err got %b want 0", proto_err); end
    cst[3] = 2'd3;
    run_msg(2'd2, 2'd3, A3, 0, 0, 0);
    checks++; if (xo_cnt !== 0) begin errors++; $display("FAIL upgr_m_xo got %0d want 0", xo_cnt); end
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL upgr_m_upd_cnt got %0d want 0", upd_cnt); end
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL upgr_m_ack_cyc got %0d want 3", ack_cyc); end
    checks++; if (shared_o !== 1'b1) begin errors++; $display("FAIL upgr_m_shared got %b want 1", shared_o); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL upgr_m_err got %b want 1", proto_err); end
  endtask

  task automatic test_rd_shared();
    cst[3] = 2'd1; ctag[3] = 23'h12;
    run_msg(2'd0, 2'd1, A3, 0, 0, 0);
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL rd_s_upd_cnt got %0d want 0", upd_cnt); end
    checks++; if (xo_cnt !== 0) begin errors++; $display("FAIL rd_s_xo got %0d want 0", xo_cnt); end
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL rd_s_ack_cyc got %0d want 3", ack_cyc); end
    checks++; if (shared_o !== 1'b1) begin errors++; $display("FAIL rd_s_shared got %b want 1", shared_o); end
  endtask

  task automatic test_miss();
    cst[3] = 2'd3; ctag[3] = 23'h13;
    run_msg(2'd2, 2'd1, A3, 0, 0, 0);
    checks++; if (ack_cyc !== 2) begin errors++; $display("FAIL miss_ack_cyc got %0d want 2", ack_cyc); end
    checks++; if (shared_o !== 1'b0) begin errors++; $display("FAIL miss_shared got %b want 0", shared_o); end
    checks++; if (upd_cnt + xo_cnt !== 0) begin errors++; $display("FAIL miss_side_effects got %0d want 0", upd_cnt + xo_cnt); end
    ctag[3] = 23'h12;
    run_msg(2'd1, 2'd1, A3, 0, 0, 0);
    checks++; if (ack_cyc !== 1) begin errors++; $display("FAIL self_ack_cyc got %0d want 1", ack_cyc); end
    checks++; if (shared_o !== 1'b0) begin errors++; $display("FAIL self_shared got %b want 0", shared_o); end
    checks++; if (upd_cnt + xo_cnt !== 0) begin errors++; $display("FAIL self_side_effects got %0d want 0", upd_cnt + xo_cnt); end
    run_msg(2'd2, 2'd0, A3, 0, 0, 0);
    checks++; if (ack_cyc !== 1) begin errors++; $display("FAIL txnone_ack_cyc got %0d want 1", ack_cyc); end
    checks++; if (shared_o !== 1'b0) begin errors++; $display("FAIL txnone_shared got %b want 0", shared_o); end
  endtask

  task automatic test_busy();
    cst[3] = 2'd3; ctag[3] = 23'h12; cdat[3] = D1;
    run_msg(2'd2, 2'd1, A3, 0, 3, 0);
    checks++; if (xo_first !== 5) begin errors++; $display("FAIL busy_xo_first got %0d want 5", xo_first); end
    checks++; if (upd_cyc !== 6) begin errors++; $display("FAIL busy_upd_cyc got %0d want 6", upd_cyc); end
    checks++; if (ack_cyc !== 7) begin errors++; $display("FAIL busy_ack_cyc got %0d want 7", ack_cyc); end
    checks++; if (xo_data_o !== D1) begin errors++; $display("FAIL busy_data got %h want %h", xo_data_o, D1); end
    checks++; if (lk_set !== 4'd3) begin errors++; $display("FAIL busy_lk_set got %0d want 3", lk_set); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL busy_err_sticky got %b want 1", proto_err); end
  endtask

  task automatic test_back_to_back();
    cst[3] = 2'd1; ctag[3] = 23'h12;
    run_msg(2'd2, 2'd1, A3, 0, 0, 5);
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL b2b_first_ack got %0d want 3", ack_cyc); end
    checks++; if (extra_acks !== 0) begin errors++; $display("FAIL b2b_held_reacks got %0d want 0", extra_acks); end
    run_msg(2'd1, 2'd2, A3, 0, 0, 0);
    checks++; if (ack_cyc !== 1) begin errors++; $display("FAIL b2b_self_ack got %0d want 1", ack_cyc); end
    run_msg(2'd3, 2'd1, mk_addr(23'h12, 4'd5), 0, 0, 0);
    checks++; if (ack_cyc !== 2) begin errors++; $display("FAIL b2b_miss_ack got %0d want 2", ack_cyc); end
    checks++; if (lk_set !== 4'd5) begin errors++; $display("FAIL b2b_lk_set got %0d want 5", lk_set); end
  endtask

  task automatic test_reset_mid_send();
    int bad;
    cst[3] = 2'd3; ctag[3] = 23'h12; cdat[3] = D1;
    bus.bus_valid = 1'b1; bus.bus_src = 2'd2; bus.bus_tx = 2'd1; bus.bus_addr = A3;
    xo_ready = 1'b0; lk_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (xo_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_xo got %b want 1", xo_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (xo_valid !== 1'b0) begin errors++; $display("FAIL rst_xo_drop got %b want 0", xo_valid); end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.snoop_ack || upd_valid || xo_valid) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_quiet got %0d want 0", bad); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_err_clear got %b want 0", proto_err); end
    rst_n = 1'b1;
    run_msg(2'd2, 2'd1, A3, 0, 0, 0);
    checks++; if (ack_cyc !== 4) begin errors++; $display("FAIL rst_rerun_ack got %0d want 4", ack_cyc); end
    checks++; if (xo_cnt !== 1) begin errors++; $display("FAIL rst_rerun_xo got %0d want 1", xo_cnt); end
    checks++; if (upd_state_o !== 2'd1) begin errors++; $display("FAIL rst_rerun_upd got %0d want 1", upd_state_o); end
    checks++; if (shared_o !== 1'b1) begin errors++; $display("FAIL rst_rerun_shared got %b want 1", shared_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    D1 = {8{32'hC0DE_0001}} ^ 256'h1234_5678;
    D2 = {8{32'h5A5A_F00D}} ^ 256'h0BAD_CAFE;
    A3 = mk_addr(23'h12, 4'd3);
    for (int i = 0; i < 16; i++) begin
      cst[i] = 2'd0; ctag[i] = '0; cdat[i] = '0;
    end
    bus.bus_valid = 1'b0; bus.bus_src = '0; bus.bus_tx = '0; bus.bus_addr = '0;
    lk_busy = 1'b0; xo_ready = 1'b0;

    test_reset();
    test_rd_m();
    test_rdx_e_stall();
    test_upgr();
    test_rd_shared();
    test_miss();
    test_busy();
    test_back_to_back();
    test_reset_mid_send();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
